// File: rtl/mips_ex_stage_if.sv
// ID/EX-to-EX/MEM bus of the MIPS execute stage, plus the MEM/WB forwarding
// inputs and the stall output back to the front end.
interface mips_ex_stage_if;
    logic        MemReadEX, MemwriteEX, MemtoregEX, RegWriteEX, RegDstEX, ALUsrcEX;
    logic [1:0]  ALUOPEX;
    logic [31:0] ReadData1EX, ReadData2EX, ImmExtEX;
    logic [4:0]  RsEX, RtEX, RdEX;
    logic        RegWriteWB;
    logic [4:0]  WriteRegWB;
    logic [31:0] WriteDataWB;
    logic [31:0] ALUResultMEM, WriteDataMEM;
    logic [4:0]  WriteRegMEM;
    logic        MemReadMEM, MemwriteMEM, MemtoregMEM, RegWriteMEM, ZeroMEM;
    logic        StallEX;

    modport master (
        output MemReadEX, MemwriteEX, MemtoregEX, RegWriteEX, RegDstEX, ALUsrcEX,
        output ALUOPEX, ReadData1EX, ReadData2EX, ImmExtEX, RsEX, RtEX, RdEX,
        output RegWriteWB, WriteRegWB, WriteDataWB,
        input  ALUResultMEM, WriteDataMEM, WriteRegMEM,
        input  MemReadMEM, MemwriteMEM, MemtoregMEM, RegWriteMEM, ZeroMEM, StallEX
    );

    modport slave (
        input  MemReadEX, MemwriteEX, MemtoregEX, RegWriteEX, RegDstEX, ALUsrcEX,
        input  ALUOPEX, ReadData1EX, ReadData2EX, ImmExtEX, RsEX, RtEX, RdEX,
        input  RegWriteWB, WriteRegWB, WriteDataWB,
        output ALUResultMEM, WriteDataMEM, WriteRegMEM,
        output MemReadMEM, MemwriteMEM, MemtoregMEM, RegWriteMEM, ZeroMEM, StallEX
    );
endinterface

// File: rtl/mips_ex_stage.sv
// MIPS execute stage: operand forwarding, ALU with R-type decode, iterative
// signed 32x32 multiplier into HI/LO, and the EX/MEM pipeline register.
module mips_ex_stage (
    input  logic          CLK,
    input  logic          RST_N,
    mips_ex_stage_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} multState_t;

    multState_t         state;
    logic [4:0]         iterCnt;
    logic [31:0]        hiReg, loReg;
    logic [63:0]        mcand, acc, partial;
    logic [31:0]        mplier;
    logic               prodNeg;

    logic signed [31:0] opA, fwdB, opB, aluRes;
    logic [5:0]         funct;
    logic               isMult, badFunct, stallEx;

    function automatic logic [31:0] absVal(input logic signed [31:0] v);
        return v[31] ? 32'(-v) : 32'(v);
    endfunction

    function automatic logic [63:0] applySign(input logic [63:0] mag, input logic neg);
        return neg ? (~mag + 64'd1) : mag;
    endfunction

    // EX/MEM wins over MEM/WB; register 0 is never forwarded.
    always_comb begin
        opA = bus.ReadData1EX;
        if (bus.RegWriteMEM && bus.WriteRegMEM != 5'd0 && bus.WriteRegMEM == bus.RsEX)
            opA = bus.ALUResultMEM;
        else if (bus.RegWriteWB && bus.WriteRegWB != 5'd0 && bus.WriteRegWB == bus.RsEX)
            opA = bus.WriteDataWB;

        fwdB = bus.ReadData2EX;
        if (bus.RegWriteMEM && bus.WriteRegMEM != 5'd0 && bus.WriteRegMEM == bus.RtEX)
            fwdB = bus.ALUResultMEM;
        else if (bus.RegWriteWB && bus.WriteRegWB != 5'd0 && bus.WriteRegWB == bus.RtEX)
            fwdB = bus.WriteDataWB;

        opB = bus.ALUsrcEX ? bus.ImmExtEX : fwdB;
    end

    assign funct = bus.ImmExtEX[5:0];

    always_comb begin
        aluRes   = '0;
        isMult   = 1'b0;
        badFunct = 1'b0;
        case (bus.ALUOPEX)
            2'b00: aluRes = opA + opB;
            2'b01: aluRes = opA - opB;
            2'b11: aluRes = opA | opB;
            default: begin
                case (funct)
                    6'h20: aluRes = opA + opB;
                    6'h22: aluRes = opA - opB;
                    6'h24: aluRes = opA & opB;
                    6'h25: aluRes = opA | opB;
                    6'h2A: aluRes = {31'd0, (opA < opB)};
                    6'h18: isMult = 1'b1;
                    6'h10: aluRes = hiReg;
                    6'h12: aluRes = loReg;
                    default: badFunct = 1'b1;
                endcase
            end
        endcase
    end

    // Stall covers the decode cycle and all BUSY cycles; DONE releases the front end.
    assign stallEx     = RST_N && ((state == IDLE && isMult) || state == BUSY);
    assign bus.StallEX = stallEx;
    assign partial     = mplier[0] ? mcand : 64'd0;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= IDLE;
            iterCnt <= '0;
            hiReg   <= '0;
            loReg   <= '0;
        end else begin
            case (state)
                IDLE: if (isMult) begin
                    mcand   <= {32'd0, absVal(opA)};
                    mplier  <= absVal(fwdB);
                    acc     <= '0;
                    prodNeg <= opA[31] ^ fwdB[31];
                    iterCnt <= '0;
                    state   <= BUSY;
                end
                BUSY: begin
                    acc     <= acc + partial;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    iterCnt <= iterCnt + 5'd1;
                    if (iterCnt == 5'd31) begin
                        {hiReg, loReg} <= applySign(acc + partial, prodNeg);
                        state          <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // EX/MEM register: bubbles keep data and clear every control bit.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            bus.ALUResultMEM <= '0;
            bus.WriteDataMEM <= '0;
            bus.WriteRegMEM  <= '0;
            bus.MemReadMEM   <= 1'b0;
            bus.MemwriteMEM  <= 1'b0;
            bus.MemtoregMEM  <= 1'b0;
            bus.RegWriteMEM  <= 1'b0;
            bus.ZeroMEM      <= 1'b0;
        end else if (stallEx || state == DONE) begin
            bus.MemReadMEM   <= 1'b0;
            bus.MemwriteMEM  <= 1'b0;
            bus.MemtoregMEM  <= 1'b0;
            bus.RegWriteMEM  <= 1'b0;
            bus.ZeroMEM      <= 1'b0;
        end else begin
            bus.ALUResultMEM <= aluRes;
            bus.WriteDataMEM <= fwdB;
            bus.WriteRegMEM  <= bus.RegDstEX ? bus.RdEX : bus.RtEX;
            bus.MemReadMEM   <= bus.MemReadEX && !badFunct;
            bus.MemwriteMEM  <= bus.MemwriteEX && !badFunct;
            bus.MemtoregMEM  <= bus.MemtoregEX;
            bus.RegWriteMEM  <= bus.RegWriteEX && !badFunct && !isMult;
            bus.ZeroMEM      <= (aluRes == 32'sd0);
        end
    end
endmodule

// File: doc/mips_ex_stage.md
MIPS_EX_STAGE -- requirements
Module: mips_ex_stage

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 32 bits.
REQ-002 Ports SHALL be as follows:
  CLK  in  1  single clock; all state updates on its rising edge
  RST_N  in  1  synchronous active-low reset
  MemReadEX, MemwriteEX, MemtoregEX, RegWriteEX, RegDstEX, ALUsrcEX  in  1 each  control from ID/EX register
  ALUOPEX  in  2  ALU op class
  ReadData1EX, ReadData2EX, ImmExtEX  in  32 each  operands and sign-extended immediate; funct = ImmExtEX[5:0]
  RsEX, RtEX, RdEX  in  5 each  register specifiers
  RegWriteWB  in  1  MEM/WB write enable, for forwarding
  WriteRegWB  in  5  MEM/WB destination register
  WriteDataWB  in  32  MEM/WB write-back data
  ALUResultMEM, WriteDataMEM  out  32 each  EX/MEM result and store data
  WriteRegMEM  out  5  EX/MEM destination register
  MemReadMEM, MemwriteMEM, MemtoregMEM, RegWriteMEM, ZeroMEM  out  1 each  EX/MEM control and zero flag
  StallEX  out  1  hold PC, IF/ID and ID/EX while high

Function
REQ-003 Operand A SHALL be ALUResultMEM if RegWriteMEM=1, WriteRegMEM!=0 and WriteRegMEM==RsEX; else WriteDataWB if RegWriteWB=1, WriteRegWB!=0 and WriteRegWB==RsEX; else ReadData1EX.
REQ-004 Forwarded B SHALL be chosen by the same rule using RtEX and ReadData2EX, with EX/MEM priority over MEM/WB.
REQ-005 ALU input B SHALL be ImmExtEX when ALUsrcEX=1, else forwarded B; WriteDataMEM SHALL always take forwarded B.
REQ-006 ALUOPEX 00 SHALL add, 01 SHALL subtract, 11 SHALL bitwise-OR, and 10 SHALL decode funct.
REQ-007 R-type funct decode SHALL be: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A signed set-less-than (result 1 or 0), 0x18 mult, 0x10 mfhi, 0x12 mflo.
REQ-008 Any other funct SHALL produce result 0 with RegWriteMEM, MemReadMEM and MemwriteMEM forced to 0.
REQ-009 Add and sub SHALL wrap modulo 2^32 with no overflow trap.
REQ-010 WriteRegMEM SHALL load RdEX when RegDstEX=1, else RtEX.
REQ-011 ZeroMEM SHALL load 1 when the ALU result is 0; the EX/MEM register latency SHALL be 1 cycle.
REQ-012 mfhi and mflo SHALL return the HI and LO registers (32 bits each) as the result.
REQ-013 mult SHALL use a 3-state FSM (IDLE, BUSY, DONE) with a 5-bit iteration counter performing signed 32x32 shift-add, one partial product per cycle.
REQ-014 IDLE with mult decoded at cycle T: the block SHALL latch operand magnitudes and result sign, clear the counter, drive StallEX=1 combinationally, and go to BUSY.
REQ-015 BUSY SHALL last exactly 32 cycles (T+1..T+32) with StallEX=1, then write the sign-corrected 64-bit product to {HI,LO} and go to DONE.
REQ-016 DONE (T+33) SHALL drive StallEX=0, load a bubble into EX/MEM, and return to IDLE, so a held mult is never restarted; the total stall is 33 cycles.
REQ-017 While StallEX=1, EX/MEM SHALL load a bubble each cycle: all control outputs 0 and data outputs unchanged.
REQ-018 Operands for mult SHALL be captured only at cycle T; later forwarding-source changes SHALL have no effect.
REQ-019 Decoding a mult SHALL never itself set RegWriteMEM.

Reset
REQ-020 On a rising edge of CLK with RST_N=0, all EX/MEM outputs, HI, LO and the counter SHALL be set to 0, and the FSM SHALL go to IDLE.
REQ-021 While reset holds the FSM in IDLE, StallEX SHALL be 0.
REQ-022 Reset during BUSY or DONE SHALL abort the multiply with no HI/LO update other than clearing to 0.

Verification
REQ-023 add with A=5, B=7, RdEX=3, RegDstEX=1: after one edge ALUResultMEM=12, WriteRegMEM=3, RegWriteMEM=1, ZeroMEM=0.
REQ-024 Forwarding chain:
  - add r3 (result 12) followed by sub rd=r3-r1 with ReadData2EX=2 -> 10 via EX/MEM forwarding.
  - EX/MEM and MEM/WB both targeting Rs -> EX/MEM value used.
  - Rs=0 with stale WB data -> ReadData1EX used.
REQ-025 mult with A=-3, B=7: StallEX high for exactly 33 cycles and RegWriteMEM=0 throughout; then mflo -> 0xFFFFFFEB and mfhi -> 0xFFFFFFFF.
REQ-026 Arithmetic and control corners:
  - slt -1,1 -> 1.
  - add 0x7FFFFFFF+1 -> 0x80000000 with no trap.
  - ALUOP 01 with equal operands -> ZeroMEM=1.
  - funct 0x3F -> result 0 and RegWriteMEM=0.
REQ-027 RST_N=0 at BUSY cycle 10: after the edge StallEX=0, FSM IDLE, HI=LO=0, all outputs 0; a new mult afterward completes normally.
